// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - keypad code lock controller with press filter, entry buffer and optional lockout
//
// Purpose:
//   Debounces a scanned keypad value into one digit event per press. Collects
//   up to DIGITS digits and checks them against a stored code on an enter
//   event. A match opens the lock for OPEN_CYCLES. A mismatch or short entry
//   pulses fail. An optional lockout phase follows MAX_FAIL consecutive
//   failures.
//
// Build option:
//   CODE_LOCK_LOCKOUT_EN - when defined, the LOCKOUT phase is compiled in.
//                          When undefined, locked is tied low and a failure
//                          always returns to IDLE.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   key_data     in   [3:0] scanned key: 0 none, 1..9 digit, 10..15 ignored
//   enter_req    in   level, rising edge requests a code check
//   clear_req    in   level, rising edge clears the entry
//   code_ref     in   [4*DIGITS-1:0] stored code, most significant digit first
//   entry_buf    out  [4*DIGITS-1:0] entered digits, newest in the low nibble
//   digit_count  out  [3:0] number of digits held
//   unlock       out  high while the lock is open
//   fail         out  one-cycle pulse on a wrong or short code
//   locked       out  high during lockout

module code_lock_ctrl #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int OPEN_CYCLES   = 16,
    parameter int MAX_FAIL      = 3,
    parameter int LOCK_CYCLES   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_data,
    input  logic                  enter_req,
    input  logic                  clear_req,
    input  logic [4*DIGITS-1:0]   code_ref,
    output logic [4*DIGITS-1:0]   entry_buf,
    output logic [3:0]            digit_count,
    output logic                  unlock,
    output logic                  fail,
    output logic                  locked
);

    localparam int SCW  = $clog2(STABLE_CYCLES + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_FAILED,
        S_LOCKOUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [4*DIGITS-1:0] entry_next;
    logic [3:0]          count_next;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       timer_next;
    logic [FW-1:0]       fail_cnt;
    logic [FW-1:0]       fail_next;
    logic [FW-1:0]       fail_inc;

    // ------------------------------------------------------------------
    // Press filter
    // ------------------------------------------------------------------
    logic [3:0]     key_q;
    logic [SCW-1:0] stab_cnt;
    logic           armed;
    logic           key_same;
    logic           key_stable;
    logic           key_is_digit;
    logic           blocked;
    logic           digit_evt;

    assign key_same     = (key_data == key_q);
    assign key_stable   = key_same && (stab_cnt == SCW'(STABLE_CYCLES - 1));
    assign key_is_digit = (key_q != 4'd0) && (key_q <= 4'd9);
    assign blocked      = (state == S_OPEN) || (state == S_FAILED) || (state == S_LOCKOUT);
    assign digit_evt    = armed && key_stable && key_is_digit && !blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q    <= 4'd0;
            stab_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            if (!key_same) begin
                key_q    <= key_data;
                stab_cnt <= '0;
            end else if (stab_cnt != SCW'(STABLE_CYCLES - 1)) begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            // Disarm after every accepted press, and keep the filter disarmed
            // while the lock is busy. Re-arm only on a stable released key.
            // Re-arming is level-based so a key already released during a
            // busy phase re-arms as soon as the phase ends.
            if (blocked || digit_evt) begin
                armed <= 1'b0;
            end else if (key_stable && (key_q == 4'd0)) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Enter / clear edge detection
    // ------------------------------------------------------------------
    logic enter_q;
    logic enter_q2;
    logic clear_q;
    logic clear_q2;
    logic enter_evt;
    logic clear_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_q  <= 1'b0;
            enter_q2 <= 1'b0;
            clear_q  <= 1'b0;
            clear_q2 <= 1'b0;
        end else begin
            enter_q  <= enter_req;
            enter_q2 <= enter_q;
            clear_q  <= clear_req;
            clear_q2 <= clear_q;
        end
    end

    assign enter_evt = enter_q && !enter_q2;
    assign clear_evt = clear_q && !clear_q2;

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            entry_buf   <= '0;
            digit_count <= 4'd0;
            timer       <= '0;
            fail_cnt    <= '0;
        end else begin
            state       <= state_next;
            entry_buf   <= entry_next;
            digit_count <= count_next;
            timer       <= timer_next;
            fail_cnt    <= fail_next;
        end
    end

    assign fail_inc = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

    always_comb begin
        state_next = state;
        entry_next = entry_buf;
        count_next = digit_count;
        timer_next = timer;
        fail_next  = fail_cnt;

        case (state)
            S_IDLE: begin
                if (digit_evt) begin
                    entry_next      = '0;
                    entry_next[3:0] = key_q;
                    count_next      = 4'd1;
                    state_next      = S_ENTRY;
                end
            end

            S_ENTRY: begin
                // Priority clear > enter > digit; losers are simply dropped.
                if (clear_evt) begin
                    entry_next = '0;
                    count_next = 4'd0;
                    state_next = S_IDLE;
                end else if (enter_evt) begin
                    state_next = S_CHECK;
                end else if (digit_evt && (digit_count != 4'(DIGITS))) begin
                    entry_next      = entry_buf << 4;
                    entry_next[3:0] = key_q;
                    count_next      = digit_count + 4'd1;
                end
            end

            S_CHECK: begin
                // The compare uses the current registers. The entry is wiped
                // on the way out, so it reads zero in OPEN and FAILED.
                entry_next = '0;
                count_next = 4'd0;
                timer_next = '0;
                if ((digit_count == 4'(DIGITS)) && (entry_buf == code_ref)) begin
                    state_next = S_OPEN;
                end else begin
                    state_next = S_FAILED;
                end
            end

            S_OPEN: begin
                fail_next = '0;
                if (timer == TW'(OPEN_CYCLES - 1)) begin
                    timer_next = '0;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end

            S_FAILED: begin
                fail_next  = fail_inc;
                timer_next = '0;
`ifdef CODE_LOCK_LOCKOUT_EN
                if (fail_inc == FW'(MAX_FAIL)) begin
                    state_next = S_LOCKOUT;
                end else begin
                    state_next = S_IDLE;
                end
`else
                state_next = S_IDLE;
`endif
            end

            S_LOCKOUT: begin
`ifdef CODE_LOCK_LOCKOUT_EN
                if (timer == TW'(LOCK_CYCLES - 1)) begin
                    timer_next = '0;
                    fail_next  = '0;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
`else
                state_next = S_IDLE;
`endif
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register
    // ------------------------------------------------------------------
    assign unlock = (state == S_OPEN);
    assign fail   = (state == S_FAILED);
`ifdef CODE_LOCK_LOCKOUT_EN
    assign locked = (state == S_LOCKOUT);
`else
    assign locked = 1'b0;
`endif

endmodule
